avalon_addr_sequencer: RTL and testbench

Parametrised Avalon-MM output-port slave that drives an address bus toward the SDRAM capture path, either by direct software write or by autonomous stepping. Software programs base, count and stride, then starts the block; each `step` pulse from the sample engine advances `out_port` by the stride until the count is exhausted. It then stops or reloads in wrap mode, flags done, and optionally raises an interrupt. It replaces fixed-width write-only address PIOs on the Nios peripheral bus.

---
 rtl/avalon_addr_seq_pkg.sv | 38 +++
 rtl/addr_seq_core.sv | 112 +++++++++++
 rtl/avalon_addr_sequencer.sv | 141 ++++++++++++++
 tb/tb_avalon_addr_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_addr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_addr_seq_pkg
// Purpose  : Shared register offsets, CONTROL/STATUS bit positions and the
//            sequencer state encoding for avalon_addr_sequencer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package avalon_addr_seq_pkg;

  // Register word offsets
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_BASE    = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_STRIDE  = 3'd3;
  localparam logic [2:0] REG_CONTROL = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  localparam logic [2:0] REG_REMAIN  = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  // CONTROL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_WRAP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Sequencer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/addr_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : addr_seq_core
// Purpose  : IDLE/RUN state machine, address accumulator and REMAIN counter.
// Ports    : clk, reset_n      - clock, async active-low reset
//            start, stop       - CONTROL pulses (stop has priority)
//            step              - advance request from the sample engine
//            data_wr, data_in  - direct DATA write (honoured only when idle)
//            wrap              - reload from shadows at end of pass
//            base/stride/count - shadow register values
//            out_addr, remain  - current address, steps left
//            busy              - high in RUN
//            done_set          - one-cycle pulse: pass finished / empty start
// Revision : 1.0 - initial release
// ============================================================================
module addr_seq_core
  import avalon_addr_seq_pkg::*;
#(
  parameter int          DATA_W      = 20,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              data_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wrap,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] out_addr,
  output logic [CNT_W-1:0]  remain,
  output logic              busy,
  output logic              done_set
);

  seq_state_e        state_q,  state_d;
  logic [DATA_W-1:0] addr_q,   addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  // Stride latched at the start of a pass so shadow writes mid-pass are inert.
  logic [DATA_W-1:0] stride_q, stride_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    stride_d = stride_q;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_wr) begin
          addr_d = data_in;
        end
        if (start && !stop) begin
          if (count != '0) begin
            addr_d   = base;
            remain_d = count;
            stride_d = stride;
            state_d  = ST_RUN;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (step) begin
          if (remain_q > CNT_W'(1)) begin
            addr_d   = addr_q + stride_q;
            remain_d = remain_q - CNT_W'(1);
          end else begin
            done_set = 1'b1;
            if (wrap && (count != '0)) begin
              // Reload picks up whatever software staged in the shadows.
              addr_d   = base;
              remain_d = count;
              stride_d = stride;
            end else begin
              remain_d = '0;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= RESET_VALUE[DATA_W-1:0];
      remain_q <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      stride_q <= stride_d;
    end
  end

  assign out_addr = addr_q;
  assign remain   = remain_q;
  assign busy     = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/avalon_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : avalon_addr_sequencer
// Purpose  : Avalon-MM slave that drives an address bus either from direct
//            software writes or by stepping BASE + n*STRIDE for COUNT steps.
// Ports    : clk, reset_n                    - clock, async active-low reset
//            address, chipselect, write_n,
//            writedata, readdata             - Avalon-MM slave, 0 wait states
//            step                            - advance request
//            out_port                        - current address
//            busy                            - sequencing in progress
//            irq                             - DONE & IRQ_EN, level
// Revision : 1.0 - initial release
// ============================================================================
module avalon_addr_sequencer
  import avalon_addr_seq_pkg::*;
#(
  parameter int          DATA_W      = 20,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              step,
  output logic [DATA_W-1:0] out_port,
  output logic              busy,
  output logic              irq
);

  logic              wr;
  logic              wr_ctrl;
  logic              start;
  logic              stop;
  logic              done_set;
  logic [CNT_W-1:0]  remain;

  logic [DATA_W-1:0] base_q,   base_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] stride_q, stride_d;
  logic              wrap_q,   wrap_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q,   done_d;

  // Upper writedata bits beyond DATA_W/CNT_W are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == REG_CONTROL);
  assign start   = wr_ctrl & writedata[CTRL_START];
  assign stop    = wr_ctrl & writedata[CTRL_STOP];

  always_comb begin
    base_d   = base_q;
    count_d  = count_q;
    stride_d = stride_q;
    wrap_d   = wrap_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (wr) begin
      case (address)
        REG_BASE:    base_d   = writedata[DATA_W-1:0];
        REG_COUNT:   count_d  = writedata[CNT_W-1:0];
        REG_STRIDE:  stride_d = writedata[DATA_W-1:0];
        REG_CONTROL: begin
          wrap_d   = writedata[CTRL_WRAP];
          irq_en_d = writedata[CTRL_IRQ_EN];
        end
        REG_STATUS:  if (writedata[STAT_DONE]) done_d = 1'b0;
        default:     ;
      endcase
    end
    // A completion in the same cycle as a clear must not be lost.
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      count_q  <= '0;
      stride_q <= '0;
      wrap_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      count_q  <= count_d;
      stride_q <= stride_d;
      wrap_q   <= wrap_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  addr_seq_core #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .RESET_VALUE (RESET_VALUE)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .data_wr  (wr && (address == REG_DATA)),
    .data_in  (writedata[DATA_W-1:0]),
    .wrap     (wrap_q),
    .base     (base_q),
    .stride   (stride_q),
    .count    (count_q),
    .out_addr (out_port),
    .remain   (remain),
    .busy     (busy),
    .done_set (done_set)
  );

  always_comb begin
    readdata = 32'd0;
    case (address)
      REG_DATA:    readdata = 32'(out_port);
      REG_BASE:    readdata = 32'(base_q);
      REG_COUNT:   readdata = 32'(count_q);
      REG_STRIDE:  readdata = 32'(stride_q);
      REG_CONTROL: readdata = 32'({irq_en_q, wrap_q, 2'b00});
      REG_STATUS:  readdata = 32'({done_q, busy});
      REG_REMAIN:  readdata = 32'(remain);
      default:     readdata = 32'd0;
    endcase
  end

  assign irq = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_addr_sequencer
// Purpose  : Directed plus randomized bench for avalon_addr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_addr_sequencer;

  localparam int          DATA_W = 20;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] MASK   = 32'h000F_FFFF;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = 3'd0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = 32'd0;
  logic [31:0]       readdata;
  logic              step = 1'b0;
  logic [DATA_W-1:0] out_port;
  logic              busy;
  logic              irq;

  int checks   = 0;
  int failures = 0;

  avalon_addr_sequencer #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .RESET_VALUE (32'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .step       (step),
    .out_port   (out_port),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Register write and step presented in the same clock cycle.
  task automatic wr_step(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; step = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; step = 1'b0;
  endtask

  // Reference: address after n accepted steps into a pass of cnt steps.
  function automatic logic [31:0] ref_addr(input logic [31:0] b, input logic [31:0] s,
                                           input int cnt, input int n, input bit wrp);
    longint k;
    k = wrp ? (n % cnt) : ((n < cnt) ? n : cnt - 1);
    return 32'((longint'(b) + k * longint'(s)) & longint'(MASK));
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] rb, rs;
    int          rc, n;
    bit          rw, s;

    // ---- reset ----
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      chk($sformatf("reset_reg%0d", i), d, 32'd0);
    end
    chk("reset_out_port", 32'(out_port), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // ---- direct DATA write ----
    wr(3'd0, 32'hFFFA_BCDE);
    chk("data_wr_out", 32'(out_port), 32'h000A_BCDE);
    rd(3'd0, d);
    chk("data_rd", d, 32'h000A_BCDE);

    // ---- basic pass ----
    wr(3'd1, 32'h100); wr(3'd3, 32'h4); wr(3'd2, 32'h3);
    wr(3'd4, 32'h1);
    chk("p1_start_out", 32'(out_port), 32'h100);
    chk("p1_start_busy", 32'(busy), 32'd1);
    wr(3'd1, 32'h999);  // shadow write mid-pass must not disturb it
    pulse_step();
    chk("p1_step1", 32'(out_port), 32'h104);
    pulse_step();
    chk("p1_step2", 32'(out_port), 32'h108);
    rd(3'd6, d);
    chk("p1_remain1", d, 32'd1);
    pulse_step();
    chk("p1_step3_out", 32'(out_port), 32'h108);
    chk("p1_step3_busy", 32'(busy), 32'd0);
    rd(3'd5, d);
    chk("p1_status_done", d, 32'h2);
    rd(3'd6, d);
    chk("p1_remain0", d, 32'd0);
    pulse_step();
    chk("p1_step4_out", 32'(out_port), 32'h108);
    chk("p1_step4_busy", 32'(busy), 32'd0);
    rd(3'd1, d);
    chk("p1_base_rb", d, 32'h999);
    wr(3'd5, 32'h2);
    rd(3'd5, d);
    chk("p1_done_clr", d, 32'd0);

    // ---- wrap with irq, across the address roll-over ----
    wr(3'd1, 32'hFFFFE); wr(3'd3, 32'h1); wr(3'd2, 32'h4);
    wr(3'd4, 32'hD);
    rd(3'd4, d);
    chk("wr_ctrl_rb", d, 32'hC);
    chk("wr_start", 32'(out_port), 32'hFFFFE);
    pulse_step(); chk("wr_s1", 32'(out_port), 32'hFFFFF);
    pulse_step(); chk("wr_s2", 32'(out_port), 32'h00000);
    pulse_step(); chk("wr_s3", 32'(out_port), 32'h00001);
    chk("wr_irq_pre", 32'(irq), 32'd0);
    pulse_step();
    chk("wr_reload", 32'(out_port), 32'hFFFFE);
    chk("wr_irq", 32'(irq), 32'd1);
    chk("wr_busy", 32'(busy), 32'd1);
    pulse_step();
    chk("wr_s5", 32'(out_port), 32'hFFFFF);
    chk("wr_irq_hold", 32'(irq), 32'd1);
    wr(3'd5, 32'h2);
    chk("wr_irq_clr", 32'(irq), 32'd0);
    pulse_step(); pulse_step();
    chk("wr_s7", 32'(out_port), 32'h00001);
    wr_step(3'd5, 32'h2);  // clear coincident with set: set wins
    chk("wr_set_wins", 32'(irq), 32'd1);
    chk("wr_reload2", 32'(out_port), 32'hFFFFE);
    wr(3'd4, 32'h2);
    chk("wr_stop_busy", 32'(busy), 32'd0);
    wr(3'd5, 32'h2);

    // ---- STOP with step, DATA write while busy ----
    wr(3'd1, 32'h200); wr(3'd3, 32'h10); wr(3'd2, 32'h5);
    wr(3'd4, 32'h1);
    pulse_step();
    chk("st_s1", 32'(out_port), 32'h210);
    wr(3'd0, 32'h55555);
    chk("st_data_ignored", 32'(out_port), 32'h210);
    wr_step(3'd4, 32'h2);
    chk("st_hold", 32'(out_port), 32'h210);
    chk("st_busy", 32'(busy), 32'd0);
    rd(3'd5, d);
    chk("st_status", d, 32'd0);

    // ---- START with COUNT=0 ----
    wr(3'd2, 32'h0);
    wr(3'd4, 32'h1);
    chk("c0_busy", 32'(busy), 32'd0);
    chk("c0_out", 32'(out_port), 32'h210);
    rd(3'd5, d);
    chk("c0_status", d, 32'h2);
    wr(3'd5, 32'h2);

    // ---- STOP beats START in same write ----
    wr(3'd2, 32'h2);
    wr(3'd4, 32'h3);
    chk("ss_busy", 32'(busy), 32'd0);
    chk("ss_out", 32'(out_port), 32'h210);

    // ---- randomized passes vs arithmetic model ----
    for (int t = 0; t < 8; t++) begin
      rb = $urandom & MASK;
      rs = $urandom & MASK;
      rc = $urandom_range(1, 6);
      rw = 1'($urandom_range(0, 1));
      wr(3'd1, rb); wr(3'd3, rs); wr(3'd2, 32'(rc));
      wr(3'd4, {28'd0, 1'b0, rw, 2'b01});
      n = 0;
      chk("rnd_start", 32'(out_port), ref_addr(rb, rs, rc, 0, rw));
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        s = 1'($urandom_range(0, 1));
        step = s;
        @(posedge clk);
        #1;
        if (s) n++;
        chk("rnd_addr", 32'(out_port), ref_addr(rb, rs, rc, n, rw));
        chk("rnd_busy", 32'(busy), (rw || n < rc) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      step = 1'b0;
      rd(3'd5, d);
      chk("rnd_done", d[1] ? 32'd1 : 32'd0, (n >= rc) ? 32'd1 : 32'd0);
      wr(3'd4, 32'h2);
      wr(3'd5, 32'h2);
    end

    // ---- asynchronous reset mid-RUN ----
    wr(3'd1, 32'h400); wr(3'd3, 32'h8); wr(3'd2, 32'h2);
    wr(3'd4, 32'hD);
    pulse_step(); pulse_step();
    chk("ar_irq_pre", 32'(irq), 32'd1);
    chk("ar_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out", 32'(out_port), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd1, d); chk("ar_base", d, 32'd0);
    rd(3'd4, d); chk("ar_ctrl", d, 32'd0);
    rd(3'd6, d); chk("ar_remain", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
